// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle add/sub/mul/rem sequencer with valid/ready
// handshakes on both sides; mul is shift-add, rem is restoring division.
module alu_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               zeroFlag,
    output logic               divByZeroFlag,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] REM  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [1:0]         op;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     r;

    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] diff;
    logic [2*WIDTH-1:0] acc_n;
    logic [WIDTH:0]     rs;
    logic [WIDTH:0]     rn;
    logic [2*WIDTH-1:0] fin;
    logic [CW-1:0]      idx;
    logic               last;
    logic               accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == MUL) || (state == REM);
    assign accept    = in_valid && in_ready;

    always_comb begin
        sum   = {{WIDTH{1'b0}}, num1} + {{WIDTH{1'b0}}, num2};
        diff  = {{WIDTH{1'b0}}, num1} - {{WIDTH{1'b0}}, num2};
        acc_n = acc;
        if (b[cnt])
            acc_n = acc + ({{WIDTH{1'b0}}, a} << cnt);
        // restoring division walks dividend bits MSB first
        idx   = CW'(WIDTH - 1) - cnt;
        rs    = {r[WIDTH-1:0], a[idx]};
        rn    = (rs >= {1'b0, b}) ? rs - {1'b0, b} : rs;
        fin   = op[0] ? {{(WIDTH-1){1'b0}}, rn} : acc_n;
        last  = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            a             <= '0;
            b             <= '0;
            op            <= '0;
            cnt           <= '0;
            acc           <= '0;
            r             <= '0;
            result        <= '0;
            zeroFlag      <= 1'b0;
            divByZeroFlag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a   <= num1;
                        b   <= num2;
                        op  <= sel;
                        cnt <= '0;
                        case (sel)
                            2'b00: begin
                                result        <= sum;
                                zeroFlag      <= (sum == '0);
                                divByZeroFlag <= 1'b0;
                                state         <= DONE;
                            end
                            2'b01: begin
                                result        <= diff;
                                zeroFlag      <= (diff == '0);
                                divByZeroFlag <= 1'b0;
                                state         <= DONE;
                            end
                            2'b10: begin
                                acc   <= '0;
                                state <= MUL;
                            end
                            default: begin
                                if (num2 == '0) begin
                                    result        <= '0;
                                    zeroFlag      <= 1'b0;
                                    divByZeroFlag <= 1'b1;
                                    state         <= DONE;
                                end else begin
                                    r     <= '0;
                                    state <= REM;
                                end
                            end
                        endcase
                    end
                end
                MUL, REM: begin
                    if (state == MUL)
                        acc <= acc_n;
                    else
                        r <= rn;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result        <= fin;
                        zeroFlag      <= (fin == '0);
                        divByZeroFlag <= 1'b0;
                        state         <= DONE;
                    end
                end
                default: begin
                    if (out_ready)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer, WIDTH = 3.
// Expected results come from an arithmetic model pushed at issue time.
module tb_alu_sequencer;

    localparam int W = 3;

    typedef struct {
        logic [2*W-1:0] r;
        logic           zf;
        logic           dz;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   num1 = '0;
    logic [W-1:0]   num2 = '0;
    logic [1:0]     sel = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] result;
    logic           zeroFlag;
    logic           divByZeroFlag;
    logic           busy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .num1(num1),
        .num2(num2),
        .sel(sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zeroFlag(zeroFlag),
        .divByZeroFlag(divByZeroFlag),
        .busy(busy)
    );

    function automatic exp_t model(int x, int y, int s);
        exp_t e;
        int   v;
        e.dz = 1'b0;
        v = 0;
        case (s)
            0: v = x + y;
            1: v = (x - y) & 63;
            2: v = x * y;
            default: begin
                if (y == 0) e.dz = 1'b1;
                else v = x % y;
            end
        endcase
        e.r  = v[2*W-1:0];
        e.zf = !e.dz && (v == 0);
        return e;
    endfunction

    // issue one op, scramble inputs after acceptance, wait for out_valid
    task automatic launch(input int x, input int y, input int s,
                          output int lat, output int bc);
        @(negedge clk);
        num1 = x[W-1:0];
        num2 = y[W-1:0];
        sel = s[1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num1 = W'($urandom);
        num2 = W'($urandom);
        sel = 2'($urandom);
        lat = 1;
        bc = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({in_ready, out_valid, result, zeroFlag, divByZeroFlag, busy} !== '0) begin
                miscompares++;
                $display("FAIL reset_outs got rdy=%0b ov=%0b res=%0d zf=%0b dz=%0b busy=%0b want all 0",
                         in_ready, out_valid, result, zeroFlag, divByZeroFlag, busy);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got rdy=%0b ov=%0b want rdy=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_addsub();
        int tbl[5][3] = '{'{7, 7, 0}, '{3, 5, 1}, '{4, 4, 1}, '{0, 0, 0}, '{0, 7, 1}};
        int lat, bc;
        exp_t e;
        foreach (tbl[i]) begin
            sb.push_back(model(tbl[i][0], tbl[i][1], tbl[i][2]));
            launch(tbl[i][0], tbl[i][1], tbl[i][2], lat, bc);
            e = sb.pop_front();
            vectors++;
            if (!out_valid || lat != 1 || result !== e.r || zeroFlag !== e.zf || divByZeroFlag !== e.dz) begin
                miscompares++;
                $display("FAIL addsub_%0d got ov=%0b lat=%0d res=%0d zf=%0b dz=%0b want lat=1 res=%0d zf=%0b dz=%0b",
                         i, out_valid, lat, result, zeroFlag, divByZeroFlag, e.r, e.zf, e.dz);
            end
            take();
        end
    endtask

    task automatic test_mul();
        int tbl[4][2] = '{'{7, 7}, '{5, 0}, '{6, 3}, '{0, 5}};
        int lat, bc;
        exp_t e;
        foreach (tbl[i]) begin
            sb.push_back(model(tbl[i][0], tbl[i][1], 2));
            launch(tbl[i][0], tbl[i][1], 2, lat, bc);
            e = sb.pop_front();
            vectors++;
            if (!out_valid || lat != 4 || bc != 3 || result !== e.r || zeroFlag !== e.zf || divByZeroFlag !== e.dz) begin
                miscompares++;
                $display("FAIL mul_%0d got ov=%0b lat=%0d busy=%0d res=%0d zf=%0b dz=%0b want lat=4 busy=3 res=%0d zf=%0b dz=%0b",
                         i, out_valid, lat, bc, result, zeroFlag, divByZeroFlag, e.r, e.zf, e.dz);
            end
            take();
        end
    endtask

    task automatic test_rem();
        int tbl[5][2] = '{'{7, 3}, '{6, 6}, '{2, 5}, '{5, 0}, '{7, 1}};
        int lat, bc, wl, wb;
        exp_t e;
        foreach (tbl[i]) begin
            wl = (tbl[i][1] == 0) ? 1 : 4;
            wb = (tbl[i][1] == 0) ? 0 : 3;
            sb.push_back(model(tbl[i][0], tbl[i][1], 3));
            launch(tbl[i][0], tbl[i][1], 3, lat, bc);
            e = sb.pop_front();
            vectors++;
            if (!out_valid || lat != wl || bc != wb || result !== e.r || zeroFlag !== e.zf || divByZeroFlag !== e.dz) begin
                miscompares++;
                $display("FAIL rem_%0d got ov=%0b lat=%0d busy=%0d res=%0d zf=%0b dz=%0b want lat=%0d busy=%0d res=%0d zf=%0b dz=%0b",
                         i, out_valid, lat, bc, result, zeroFlag, divByZeroFlag, wl, wb, e.r, e.zf, e.dz);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat, bc;
        exp_t e;
        sb.push_back(model(6, 3, 2));
        launch(6, 3, 2, lat, bc);
        e = sb.pop_front();
        num1 = 3'd1;
        num2 = 3'd1;
        sel = 2'd0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (!out_valid || in_ready || result !== e.r || zeroFlag !== e.zf || divByZeroFlag !== e.dz) begin
                miscompares++;
                $display("FAIL hold_%0d got ov=%0b rdy=%0b res=%0d zf=%0b dz=%0b want ov=1 rdy=0 res=%0d zf=%0b dz=%0b",
                         k, out_valid, in_ready, result, zeroFlag, divByZeroFlag, e.r, e.zf, e.dz);
            end
        end
        sb.push_back(model(1, 1, 0));
        take();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handshake_gap got ov=%0b rdy=%0b want ov=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (out_valid !== 1'b1 || result !== e.r) begin
            miscompares++;
            $display("FAIL next_op got ov=%0b res=%0d want ov=1 res=%0d", out_valid, result, e.r);
        end
        take();
    endtask

    task automatic test_reset_mid_mul();
        int seen = 0;
        @(negedge clk);
        num1 = 3'd7;
        num2 = 3'd7;
        sel = 2'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy || out_valid || in_ready || result !== '0) begin
            miscompares++;
            $display("FAIL mid_rst got busy=%0b ov=%0b rdy=%0b res=%0d want all 0",
                     busy, out_valid, in_ready, result);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        vectors++;
        if (seen != 0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_after got active=%0d rdy=%0b want active=0 rdy=1", seen, in_ready);
        end
    endtask

    task automatic test_random();
        int x, y, s, lat, bc;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            x = $urandom_range(7);
            y = $urandom_range(7);
            s = $urandom_range(3);
            sb.push_back(model(x, y, s));
            launch(x, y, s, lat, bc);
            e = sb.pop_front();
            vectors++;
            if (!out_valid || result !== e.r || zeroFlag !== e.zf || divByZeroFlag !== e.dz) begin
                miscompares++;
                $display("FAIL rand_%0d op=%0d a=%0d b=%0d got ov=%0b res=%0d zf=%0b dz=%0b want res=%0d zf=%0b dz=%0b",
                         i, s, x, y, out_valid, result, zeroFlag, divByZeroFlag, e.r, e.zf, e.dz);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_rem();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
